riscv_axi_lite_master: RTL and testbench
========================================

// Module: riscv_axi_lite_master
// PURPOSE
// - AXI4-Lite master bridge between the RISC-V core's simple memory port and AXI4-Lite slaves (RAM, UART window).
// - Converts one core request (read or write) into one AXI4-Lite transaction.
// - Returns a one-cycle completion pulse with read data and an error flag.
// - Single outstanding transaction; no bursts, no reordering.
// PARAMETERS
// - ADDR_W  32  address width, core side and AXI side
// - DATA_W  32  data width; strobe width is DATA_W/8
// PORTS
// - clk            in   1         clock, all logic on posedge
// - rst            in   1         synchronous, active-high reset
// - mem_req        in   1         core request; held high until mem_ready
// - mem_we         in   1         1 = write, 0 = read
// - mem_addr       in   ADDR_W    byte address
// - mem_wdata      in   DATA_W    write data
// - mem_wstrb      in   DATA_W/8  byte enables for the write
// - mem_ready      out  1         1-cycle completion pulse
// - mem_rdata      out  DATA_W    read data; valid while mem_ready=1, then held
// - mem_err        out  1         1 with mem_ready when the response was not OKAY
// - M_AXI_AWADDR/AWVALID out, AWREADY in   write address channel
// - M_AXI_WDATA/WSTRB/WVALID out, WREADY in  write data channel
// - M_AXI_BRESP[1:0]/BVALID in, BREADY out  write response channel
// - M_AXI_ARADDR/ARVALID out, ARREADY in   read address channel
// - M_AXI_RDATA/RRESP[1:0]/RVALID in, RREADY out  read data channel
// BEHAVIOUR
// - Reset: all outputs registered, all 0.
//   - Covers every VALID, BREADY, RREADY, mem_ready, mem_err, mem_rdata and all address/data regs.
//   - State = IDLE.
// - FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
// - IDLE, mem_req=1:
//   - Latch addr, wdata and wstrb; AxADDR = {mem_addr[ADDR_W-1:2], 2'b00}.
//   - mem_we=1 -> WR_REQ with AWVALID=WVALID=1 next cycle.
//   - mem_we=0 -> RD_REQ with ARVALID=1 next cycle.
// - WR_REQ:
//   - AW and W handshake independently; each VALID drops the cycle after its own VALID&READY edge.
//   - Handshakes may occur in the same cycle or in either order.
//   - When both are done -> WR_RESP with BREADY=1.
// - WR_RESP: on BVALID&BREADY
//   - mem_ready=1 for one cycle; mem_err=(BRESP!=2'b00).
//   - BREADY=0; -> IDLE.
// - RD_REQ: on ARVALID&ARREADY -> ARVALID=0, RREADY=1, -> RD_RESP.
// - RD_RESP: on RVALID&RREADY
//   - mem_rdata<=RDATA; mem_ready=1 for one cycle; mem_err=(RRESP!=2'b00).
//   - RREADY=0; -> IDLE.
// - AXI rules:
//   - VALID never depends on READY combinationally.
//   - Once VALID is asserted, it stays high and payload stays stable until the handshake.
//   - BREADY and RREADY are low outside their response states; stray BVALID/RVALID are ignored.
// - mem_req is ignored while not in IDLE (latched copy is used).
// - A new request is accepted no earlier than the cycle after mem_ready.
// - mem_err is cleared on the next accepted request.
// - Latency with a zero-wait slave (READY high, response 1 cycle after handshake): req -> mem_ready = 4 cycles.
// - No timeout: a stalled slave stalls the bridge indefinitely.
// - Reset mid-transaction: immediate return to IDLE, all VALID/READY low; the transaction is abandoned (system reset resets both ends).
// STRUCTURE
// - Shared package riscv_axi_pkg:
//   - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//   - FSM state typedef/localparams.
//   - UART_TX_ADDR=32'h8000_0000.
// - No sub-module; single flat FSM plus aw_done/w_done flags and payload regs.
// TESTING
// - Write 0xDEADBEEF, strb 4'hF to 0x0000_0010, slave always ready
//   -> AWADDR=0x10, WDATA=0xDEADBEEF; one mem_ready, mem_err=0; RAM word 4 updated.
// - Read 0x0000_0010 after that write -> mem_rdata=0xDEADBEEF with mem_ready, mem_err=0.
// - WREADY delayed 3 cycles after AWREADY -> AWVALID drops first; WDATA stable until handshake; BREADY rises only after both.
// - Slave returns RRESP=2'b10 on read of 0x0000_0FFC -> mem_ready=1, mem_err=1; next OKAY read clears mem_err.
// - Write 0x0000_0041 to 0x8000_0000 -> AWADDR=0x80000000; UART prints 'A'; mem_ready after BVALID.
// - rst asserted while in WR_RESP with BVALID low -> next cycle all VALID/READY=0, mem_ready=0; a new read then completes normally.

Source files
------------

// File: rtl/riscv_axi_pkg.sv
// Shared definitions for the core-to-AXI4-Lite bridge: response codes, FSM states,
// and the fixed UART transmit window address.
package riscv_axi_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] UART_TX_ADDR = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_e;
endpackage

// File: rtl/riscv_axi_lite_master.sv
// Single-outstanding bridge turning one core memory request into one AXI4-Lite
// transaction; every output comes straight from a register.
module riscv_axi_lite_master
  import riscv_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_err,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                ready_q, ready_d, err_q, err_d;
  logic                aw_hs, w_hs;

  assign aw_hs = awvalid_q & M_AXI_AWREADY;
  assign w_hs  = wvalid_q & M_AXI_WREADY;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    ready_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The core still holds mem_req in the cycle its completion is visible.
        if (mem_req && !ready_q) begin
          addr_d    = mem_addr & WORD_MASK;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (mem_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID && bready_q) begin
          ready_d  = 1'b1;
          err_d    = (M_AXI_BRESP != RESP_OKAY);
          bready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (M_AXI_RVALID && rready_q) begin
          rdata_d  = M_AXI_RDATA;
          ready_d  = 1'b1;
          err_d    = (M_AXI_RRESP != RESP_OKAY);
          rready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  assign mem_ready     = ready_q;
  assign mem_rdata     = rdata_q;
  assign mem_err       = err_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_riscv_axi_lite_master.sv
// Bench for the AXI4-Lite bridge: behavioural RAM/UART slave, word-level reference
// memory feeding a scoreboard, and a negedge monitor with AXI handshake rules.
module tb_riscv_axi_lite_master;
  import riscv_axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_req, mem_we, mem_ready, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  riscv_axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] o;
    o = old;
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  // ---------------- slave model ----------------
  // 0 zero-wait, 1 random stalls, 2 late WREADY, 3 write response withheld
  int          slave_mode = 0;
  logic [31:0] slv_mem [bit [31:0]];
  logic        s_aw_got, s_w_got, s_bpend, s_rpend;
  int          s_bcnt, s_rcnt, s_age, next_lat;
  logic [31:0] s_awaddr, s_wdata, last_awaddr, last_wdata;
  logic [3:0]  s_wstrb;
  logic [7:0]  uart_char = 8'h00;
  int          uart_cnt = 0;
  logic        aw_hs, w_hs, ar_hs, wr_go;
  logic [31:0] wr_a, wr_d;
  logic [3:0]  wr_s;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;
  assign wr_go = (s_aw_got || aw_hs) && (s_w_got || w_hs);
  assign wr_a  = aw_hs ? awaddr : s_awaddr;
  assign wr_d  = w_hs ? wdata : s_wdata;
  assign wr_s  = w_hs ? wstrb : s_wstrb;

  // Strict slave: unaligned addresses are rejected so a bridge that forgets to align shows up.
  function automatic logic [1:0] slv_resp(input logic [31:0] a, input bit is_rd);
    if (a[1:0] != 2'b00) return RESP_SLVERR;
    if (a >= 32'hF000_0000) return RESP_DECERR;
    if (is_rd && a == 32'h0000_0FFC) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] slv_rd(input logic [31:0] w);
    return slv_mem.exists(w) ? slv_mem[w] : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= 32'h0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; s_bpend <= 1'b0; s_rpend <= 1'b0;
      s_bcnt <= 0; s_rcnt <= 0; s_age <= 0; next_lat <= 0;
      s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0;
    end else begin
      case (slave_mode)
        1: begin
          awready <= 1'($urandom_range(0, 1));
          wready  <= 1'($urandom_range(0, 1));
          arready <= 1'($urandom_range(0, 1));
        end
        2: begin
          awready <= 1'b1; arready <= 1'b1;
          wready  <= s_aw_got && (s_age >= 2);
        end
        default: begin awready <= 1'b1; wready <= 1'b1; arready <= 1'b1; end
      endcase
      next_lat <= (slave_mode == 1) ? int'($urandom_range(0, 3)) :
                  (slave_mode == 3) ? 100000 : 0;
      if (s_aw_got && !s_w_got) s_age <= s_age + 1; else s_age <= 0;
      if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; last_awaddr <= awaddr; end
      if (w_hs) begin
        s_w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; last_wdata <= wdata;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (s_bpend) begin
        if (s_bcnt == 0) begin bvalid <= 1'b1; s_bpend <= 1'b0; end
        else s_bcnt <= s_bcnt - 1;
      end
      if (wr_go) begin
        s_aw_got <= 1'b0; s_w_got <= 1'b0;
        bresp <= slv_resp(wr_a, 1'b0);
        if (next_lat == 0) bvalid <= 1'b1;
        else begin s_bpend <= 1'b1; s_bcnt <= next_lat - 1; end
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (s_rpend) begin
        if (s_rcnt == 0) begin rvalid <= 1'b1; s_rpend <= 1'b0; end
        else s_rcnt <= s_rcnt - 1;
      end
      if (ar_hs) begin
        rresp <= slv_resp(araddr, 1'b1);
        rdata <= (slv_resp(araddr, 1'b1) == RESP_OKAY) ? slv_rd(araddr >> 2) : 32'hBAD0_BAD0;
        if (next_lat == 0) rvalid <= 1'b1;
        else begin s_rpend <= 1'b1; s_rcnt <= next_lat - 1; end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && wr_go && slv_resp(wr_a, 1'b0) == RESP_OKAY) begin
      if (wr_a == UART_TX_ADDR) begin
        uart_char = wr_d[7:0];
        uart_cnt++;
        $display("UART tx: %c", wr_d[7:0]);
      end else begin
        slv_mem[wr_a >> 2] = merge(slv_rd(wr_a >> 2), wr_d, wr_s);
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [bit [31:0]];

  function automatic exp_t model(input bit we, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
    exp_t        e;
    logic [31:0] wa;
    bit   [31:0] w;
    wa      = {a[31:2], 2'b00};
    w       = 32'(wa / 4);
    e.rd    = !we;
    e.err   = (wa >= 32'hF000_0000) || (!we && wa == 32'h0000_0FFC);
    e.rdata = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    if (we && !e.err && wa != UART_TX_ADDR)
      ref_mem[w] = merge(e.rdata, d, s);
    return e;
  endfunction

  // ---------------- monitor ----------------
  exp_t        mon_e;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rdy, p_br;
  logic [31:0] p_awa, p_wd, p_ara, held_rdata;
  logic [3:0]  p_ws;
  int          cyc = 0, aw_hs_cyc = -1, w_hs_cyc = -1, brise_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rdy = 0; p_br = 0;
      held_rdata = 32'h0;
    end else begin
      if (mem_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_ready: mem_ready=1 with no request outstanding");
        end else begin
          mon_e = sb.pop_front();
          check("mem_err", {31'h0, mem_err}, {31'h0, mon_e.err});
          if (mon_e.rd && !mon_e.err) check("mem_rdata", mem_rdata, mon_e.rdata);
          if (mon_e.rd) held_rdata = mem_rdata;
          else check("rdata_held_on_write", mem_rdata, held_rdata);
        end
      end
      if (p_rdy) check("ready_one_cycle", {31'h0, mem_ready}, 32'h0);
      if (p_awv && !p_awr) begin
        check("awvalid_hold", {31'h0, awvalid}, 32'h1);
        check("awaddr_stable", awaddr, p_awa);
      end
      if (p_wv && !p_wr) begin
        check("wvalid_hold", {31'h0, wvalid}, 32'h1);
        check("wdata_stable", wdata, p_wd);
        check("wstrb_stable", {28'h0, wstrb}, {28'h0, p_ws});
      end
      if (p_arv && !p_arr) begin
        check("arvalid_hold", {31'h0, arvalid}, 32'h1);
        check("araddr_stable", araddr, p_ara);
      end
      if (bready) check("bready_after_aw_w", {31'h0, awvalid | wvalid | arvalid}, 32'h0);
      if (rready) check("rready_after_ar", {31'h0, arvalid | awvalid | wvalid}, 32'h0);
      if (aw_hs) aw_hs_cyc = cyc;
      if (w_hs) w_hs_cyc = cyc;
      if (bready && !p_br) brise_cyc = cyc;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv = wvalid; p_wr = wready; p_wd = wdata; p_ws = wstrb;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_rdy = mem_ready; p_br = bready;
    end
  end

  // ---------------- driver ----------------
  int last_lat;

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    int t;
    sb.push_back(model(we, a, d, s));
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_ready && t < 300);
    last_lat = t;
    if (!mem_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: no mem_ready after %0d cycles, expected one", t);
      sb.delete();
    end
    // A core sampling on the clock still shows the old request for one more edge.
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'($urandom_range(0, 1)); mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] a, d;
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
    check("rst_mem_err", {31'h0, mem_err}, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_valids", {28'h0, awvalid, wvalid, arvalid, 1'b0}, 32'h0);
    check("rst_readys", {30'h0, bready, rready}, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_wstrb", {28'h0, wstrb}, 32'h0);
    rst = 1'b0;

    // zero-wait write, then readback
    slave_mode = 0;
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    check("wr_awaddr", last_awaddr, 32'h0000_0010);
    check("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    check("ram_word4", slv_rd(32'h4), 32'hDEAD_BEEF);
    // request cycle counts as the first; completion visible in the fourth
    check("zero_wait_latency", 32'(last_lat), 32'd3);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);

    // W accepted well after AW
    slave_mode = 2;
    aw_hs_cyc = -1; w_hs_cyc = -1; brise_cyc = -1;
    do_req(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF);
    check("aw_before_w", 32'(w_hs_cyc - aw_hs_cyc >= 3), 32'h1);
    check("bready_after_both", 32'(brise_cyc > w_hs_cyc && brise_cyc > aw_hs_cyc), 32'h1);
    slave_mode = 0;

    // error read then OKAY read clears the flag; partial-strobe write
    do_req(1'b0, 32'h0000_0FFC, 32'h0, 4'h0);
    do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
    do_req(1'b1, 32'h0000_0012, 32'hAABB_CCDD, 4'b0100);
    do_req(1'b0, 32'h0000_0010, 32'h0, 4'h0);

    // UART window
    do_req(1'b1, UART_TX_ADDR, 32'h0000_0041, 4'h1);
    check("uart_awaddr", last_awaddr, 32'h8000_0000);
    check("uart_char", {24'h0, uart_char}, 32'h41);

    // reset while waiting on a withheld write response
    slave_mode = 3;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0030; mem_wdata = 32'hCAFE_F00D;
    mem_wstrb = 4'hF;
    void'(model(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF));
    t = 0;
    do begin @(negedge clk); t++; end while (!bready && t < 50);
    check("reached_wr_resp", {31'h0, bready}, 32'h1);
    check("bvalid_low_in_wr_resp", {31'h0, bvalid}, 32'h0);
    rst = 1'b1; mem_req = 1'b0;
    @(negedge clk);
    check("midrst_valids", {29'h0, awvalid, wvalid, arvalid}, 32'h0);
    check("midrst_readys", {29'h0, bready, rready, mem_ready}, 32'h0);
    sb.delete();
    rst = 1'b0;
    slave_mode = 0;
    do_req(1'b0, 32'h0000_0030, 32'h0, 4'h0);

    // randomized traffic with random stalls and response latency
    slave_mode = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        7:       a = 32'h0000_0FFC | 32'($urandom_range(0, 3));
        8:       a = 32'hF000_0000 + 32'($urandom_range(0, 255));
        9:       a = UART_TX_ADDR;
        default: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      endcase
      d = (a == UART_TX_ADDR) ? 32'h41 + 32'($urandom_range(0, 25)) : $urandom;
      do_req(1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
